// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: multi-cycle FSM fetching instructions and data from one
// unified memory over a REQ/ACK handshake that tolerates wait states.
module acc_cpu_core #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    input  logic          MEM_ACK,
    output logic [AW-1:0] Q_PC,
    output logic [DW-1:0] Q_IR,
    output logic [DW-1:0] Dout_ACC,
    output logic          FLAG_Z,
    output logic          FLAG_C,
    output logic [2:0]    STATE,
    output logic          HALT
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StMem    = 3'd2,
        StExec   = 3'd3,
        StHalt   = 3'd4
    } state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpLd   = 4'h1;
    localparam logic [3:0] OpSt   = 4'h2;
    localparam logic [3:0] OpAdd  = 4'h3;
    localparam logic [3:0] OpSub  = 4'h4;
    localparam logic [3:0] OpAnd  = 4'h5;
    localparam logic [3:0] OpOr   = 4'h6;
    localparam logic [3:0] OpXor  = 4'h7;
    localparam logic [3:0] OpShl  = 4'h8;
    localparam logic [3:0] OpShr  = 4'h9;
    localparam logic [3:0] OpNot  = 4'hA;
    localparam logic [3:0] OpJmp  = 4'hB;
    localparam logic [3:0] OpJz   = 4'hC;
    localparam logic [3:0] OpJc   = 4'hD;
    localparam logic [3:0] OpLdi  = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] dr_q, dr_d;
    logic          z_q, z_d;
    logic          c_q, c_d;
    logic          acc_wr;

    logic [3:0]    op;
    logic [DW-5:0] k;
    logic [AW-1:0] addr;
    logic [DW:0]   sum;
    logic [DW:0]   diff;

    assign op   = ir_q[DW-1:DW-4];
    assign k    = ir_q[DW-5:0];
    assign addr = k[AW-1:0];
    assign sum  = {1'b0, acc_q} + {1'b0, dr_q};
    // Top bit of the extended difference is the borrow (A < M unsigned).
    assign diff = {1'b0, acc_q} - {1'b0, dr_q};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            dr_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            dr_q    <= dr_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        dr_d    = dr_q;
        z_d     = z_q;
        c_d     = c_q;
        acc_wr  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (MEM_ACK) begin
                    ir_d    = MEM_RDATA;
                    pc_d    = pc_q + AW'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (op)
                    OpLd, OpSt, OpAdd, OpSub, OpAnd, OpOr, OpXor: state_d = StMem;
                    OpHalt:                                       state_d = StHalt;
                    default:                                      state_d = StExec;
                endcase
            end
            StMem: begin
                if (MEM_ACK) begin
                    dr_d    = MEM_RDATA;
                    state_d = (op == OpSt) ? StFetch : StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                case (op)
                    OpLd:  begin acc_d = dr_q;                 c_d = 1'b0;        acc_wr = 1'b1; end
                    OpAdd: begin acc_d = sum[DW-1:0];          c_d = sum[DW];     acc_wr = 1'b1; end
                    OpSub: begin acc_d = diff[DW-1:0];         c_d = diff[DW];    acc_wr = 1'b1; end
                    OpAnd: begin acc_d = acc_q & dr_q;         c_d = 1'b0;        acc_wr = 1'b1; end
                    OpOr:  begin acc_d = acc_q | dr_q;         c_d = 1'b0;        acc_wr = 1'b1; end
                    OpXor: begin acc_d = acc_q ^ dr_q;         c_d = 1'b0;        acc_wr = 1'b1; end
                    OpShl: begin acc_d = acc_q << 1;           c_d = acc_q[DW-1]; acc_wr = 1'b1; end
                    OpShr: begin acc_d = acc_q >> 1;           c_d = acc_q[0];    acc_wr = 1'b1; end
                    OpNot: begin acc_d = ~acc_q;               c_d = 1'b0;        acc_wr = 1'b1; end
                    OpLdi: begin acc_d = DW'(k);               c_d = 1'b0;        acc_wr = 1'b1; end
                    OpJmp: pc_d = addr;
                    // Flags cannot change between DECODE and EXEC, so these are the DECODE-time flags.
                    OpJz:  if (z_q) pc_d = addr;
                    OpJc:  if (c_q) pc_d = addr;
                    default: ;
                endcase
                if (acc_wr) z_d = (acc_d == '0);
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
    end

    // RESET gates the request so an outstanding access is dropped without a clock edge.
    assign MEM_REQ   = ~RESET & ((state_q == StFetch) | (state_q == StMem));
    assign MEM_WE    = ~RESET & (state_q == StMem) & (op == OpSt);
    assign MEM_ADDR  = (state_q == StMem) ? addr : pc_q;
    assign MEM_WDATA = acc_q;

    assign Q_PC     = pc_q;
    assign Q_IR     = ir_q;
    assign Dout_ACC = acc_q;
    assign FLAG_Z   = z_q;
    assign FLAG_C   = c_q;
    assign STATE    = state_q;
    assign HALT     = (state_q == StHalt);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Randomized and directed bench for acc_cpu_core against an instruction-level reference model.
module tb_acc_cpu_core;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          MEM_REQ, MEM_WE, MEM_ACK;
    logic [AW-1:0] MEM_ADDR, Q_PC;
    logic [DW-1:0] MEM_WDATA, MEM_RDATA, Q_IR, Dout_ACC;
    logic          FLAG_Z, FLAG_C, HALT;
    logic [2:0]    STATE;

    acc_cpu_core #(.DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .Q_PC(Q_PC),
        .Q_IR(Q_IR), .Dout_ACC(Dout_ACC), .FLAG_Z(FLAG_Z), .FLAG_C(FLAG_C), .STATE(STATE),
        .HALT(HALT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: wait mode 0 = zero-wait, 1 = three waits, 2 = random 0..3 per access.
    logic [7:0] mem [16];
    logic [7:0] img [16];
    int  wmode = 0;
    int  wait_n = 0;
    int  cnt = 0;
    int  wait_total = 0;
    bit  block_mem = 1'b0;

    function automatic int pick_wait();
        if (wmode == 1) return 3;
        if (wmode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    assign MEM_RDATA = mem[MEM_ADDR];
    assign MEM_ACK   = MEM_REQ && (cnt >= wait_n) && !(block_mem && STATE == 3'd2);

    always @(posedge CLK) begin
        if (RESET) begin
            mem        <= img;
            cnt        <= 0;
            wait_total <= 0;
            wait_n     <= pick_wait();
        end else if (MEM_REQ && MEM_ACK) begin
            if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
            cnt    <= 0;
            wait_n <= pick_wait();
        end else if (MEM_REQ) begin
            cnt        <= cnt + 1;
            wait_total <= wait_total + 1;
        end
    end

    // Request attributes must hold while an access is waiting.
    logic        stab_v = 1'b0;
    logic [12:0] stab_val = '0;
    always @(posedge CLK) begin
        stab_v   <= !RESET && MEM_REQ && !MEM_ACK;
        stab_val <= {MEM_WE, MEM_ADDR, MEM_WDATA};
    end
    always @(negedge CLK) begin
        if (stab_v && !RESET) begin
            check("req_hold_req", 32'(MEM_REQ), 32'd1);
            check("req_hold_attr", 32'({MEM_WE, MEM_ADDR, MEM_WDATA}), 32'(stab_val));
        end
    end

    // Instruction-level reference model.
    int m_mem [16];
    int m_a, m_z, m_c, m_pc, m_cyc, m_acc;
    bit m_halted;

    task automatic model_run();
        int ir, op, k, t;
        for (int i = 0; i < 16; i++) m_mem[i] = int'(img[i]);
        m_a = 0; m_z = 0; m_c = 0; m_pc = 0; m_cyc = 0; m_acc = 0; m_halted = 1'b0;
        for (int n = 0; n < 200 && !m_halted; n++) begin
            ir   = m_mem[m_pc];
            m_pc = (m_pc + 1) % 16;
            op   = ir / 16;
            k    = ir % 16;
            m_acc++;
            if (op >= 1 && op <= 7) begin
                m_acc++;
                m_cyc += (op == 2) ? 3 : 4;
            end else if (op == 15) begin
                m_cyc += 2;
            end else begin
                m_cyc += 3;
            end
            case (op)
                1:  begin m_a = m_mem[k]; m_c = 0; end
                2:  m_mem[k] = m_a;
                3:  begin t = m_a + m_mem[k]; m_c = (t > 255); m_a = t % 256; end
                4:  begin m_c = (m_a < m_mem[k]); m_a = (m_a - m_mem[k] + 256) % 256; end
                5:  begin m_a = m_a & m_mem[k]; m_c = 0; end
                6:  begin m_a = m_a | m_mem[k]; m_c = 0; end
                7:  begin m_a = m_a ^ m_mem[k]; m_c = 0; end
                8:  begin m_c = m_a / 128; m_a = (m_a * 2) % 256; end
                9:  begin m_c = m_a % 2; m_a = m_a / 2; end
                10: begin m_a = 255 - m_a; m_c = 0; end
                11: m_pc = k;
                12: if (m_z == 1) m_pc = k;
                13: if (m_c == 1) m_pc = k;
                14: begin m_a = k; m_c = 0; end
                15: m_halted = 1'b1;
                default: ;
            endcase
            if ((op == 1) || (op >= 3 && op <= 10) || op == 14) m_z = (m_a == 0);
        end
    endtask

    int last_cycles;

    task automatic run_prog(input string name, input int mode);
        int bad;
        bit done;
        model_run();
        @(negedge CLK);
        RESET = 1'b1;
        wmode = mode;
        block_mem = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check({name, ":rst_ctl"}, 32'({STATE, HALT, MEM_REQ, MEM_WE, FLAG_Z, FLAG_C}), 32'd0);
        check({name, ":rst_regs"}, 32'({Q_PC, Q_IR, Dout_ACC}), 32'd0);
        RESET = 1'b0;
        last_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(posedge CLK);
            #1;
            last_cycles++;
            if (HALT) done = 1'b1;
        end
        check({name, ":halted"}, 32'(HALT), 32'd1);
        check({name, ":cycles"}, 32'(last_cycles), 32'(m_cyc + wait_total));
        if (mode == 0) check({name, ":waits"}, 32'(wait_total), 32'd0);
        if (mode == 1) check({name, ":waits"}, 32'(wait_total), 32'(3 * m_acc));
        check({name, ":acc"}, 32'(Dout_ACC), 32'(m_a));
        check({name, ":z"}, 32'(FLAG_Z), 32'(m_z));
        check({name, ":c"}, 32'(FLAG_C), 32'(m_c));
        check({name, ":pc"}, 32'(Q_PC), 32'(m_pc));
        check({name, ":state"}, 32'(STATE), 32'd4);
        for (int i = 0; i < 16; i++) check({name, ":mem"}, 32'(mem[i]), 32'(m_mem[i]));
        bad = 0;
        repeat (20) begin
            @(posedge CLK);
            #1;
            if (!HALT || MEM_REQ) bad++;
        end
        check({name, ":halt_hold"}, 32'(bad), 32'd0);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
    endtask

    initial begin
        int tries;
        bit ok;

        // Program 1: LD 10, ADD 11, ST 12, HALT.
        clear_img();
        img[0] = 8'h1A; img[1] = 8'h3B; img[2] = 8'h2C; img[3] = 8'hF0;
        img[10] = 8'h25; img[11] = 8'h1C;
        run_prog("p1_zw", 0);
        check("p1_zw:acc_41", 32'(Dout_ACC), 32'h41);
        check("p1_zw:m12_41", 32'(mem[12]), 32'h41);
        check("p1_zw:pc_4", 32'(Q_PC), 32'd4);
        check("p1_zw:cyc_13", 32'(last_cycles), 32'd13);
        run_prog("p1_w3", 1);
        check("p1_w3:acc_41", 32'(Dout_ACC), 32'h41);
        check("p1_w3:m12_41", 32'(mem[12]), 32'h41);

        // Borrow then JC taken.
        clear_img();
        img[0] = 8'hE3; img[1] = 8'h4A; img[2] = 8'hD8; img[8] = 8'hF0; img[10] = 8'h05;
        run_prog("borrow_jc", 0);
        check("borrow_jc:acc_fe", 32'(Dout_ACC), 32'hFE);
        check("borrow_jc:pc_9", 32'(Q_PC), 32'd9);

        // SHL via LD 81, SHR of 1, NOT of F.
        clear_img();
        img[0] = 8'h1A; img[1] = 8'h80; img[2] = 8'hF0; img[10] = 8'h81;
        run_prog("shl", 0);
        check("shl:acc_c", 32'({Dout_ACC, FLAG_C}), 32'({8'h02, 1'b1}));
        clear_img();
        img[0] = 8'hE1; img[1] = 8'h90; img[2] = 8'hF0;
        run_prog("shr", 2);
        check("shr:acc_c_z", 32'({Dout_ACC, FLAG_C, FLAG_Z}), 32'({8'h00, 1'b1, 1'b1}));
        clear_img();
        img[0] = 8'hEF; img[1] = 8'hA0; img[2] = 8'hF0;
        run_prog("not", 0);
        check("not:acc_c_z", 32'({Dout_ACC, FLAG_C, FLAG_Z}), 32'({8'hF0, 1'b0, 1'b0}));

        // JZ falls through, JMP F, LDI 0 wraps PC to 0, JZ now taken to 5.
        clear_img();
        img[0] = 8'hC5; img[1] = 8'hBF; img[15] = 8'hE0; img[5] = 8'hF0;
        run_prog("wrap_jz", 0);
        check("wrap_jz:pc_6", 32'(Q_PC), 32'd6);

        // Random programs that the model shows halting.
        for (int r = 0; r < 30; r++) begin
            tries = 0;
            ok = 1'b0;
            while (!ok && tries < 1000) begin
                for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
                model_run();
                ok = m_halted;
                tries++;
            end
            if (ok) run_prog($sformatf("rnd%0d", r), r % 3);
        end

        // Asynchronous reset while a data read is stalled.
        clear_img();
        img[0] = 8'hE5; img[1] = 8'h1A; img[10] = 8'h77;
        @(negedge CLK);
        RESET = 1'b1;
        wmode = 0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        block_mem = 1'b1;
        RESET = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge CLK);
            #1;
            if (STATE == 3'd2) ok = 1'b1;
        end
        check("arst:reached_mem", 32'(STATE), 32'd2);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("arst:pre_req_addr", 32'({MEM_REQ, MEM_ADDR, Dout_ACC}), 32'({1'b1, 4'hA, 8'h05}));
        #2;
        RESET = 1'b1;
        #1;
        check("arst:req", 32'(MEM_REQ), 32'd0);
        check("arst:pc_acc", 32'({Q_PC, Dout_ACC}), 32'd0);
        check("arst:state", 32'(STATE), 32'd0);
        block_mem = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("arst:first_req", 32'({MEM_REQ, MEM_WE, MEM_ADDR}), 32'({1'b1, 1'b0, 4'h0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
